cpu6_memarb: RTL
================

// Module: cpu6_memarb
// PURPOSE
//  Shares one single-ported memory between the fetch stage (I port) and the MEM stage (D port).
//  Arbitrates between the two ports with a locked grant: the winner keeps the memory until its transaction completes.
//  Data requests win by default; a starvation counter bounds how long fetch can be kept waiting.
//  A flush input (driven from pcsrcE) cancels the response of a fetch that is no longer wanted.
// PARAMETERS
//  XLEN        32  address/data width (matches `CPU6_XLEN)
//  STARVE_MAX  4   consecutive D grants with ireq pending before I is forced to win
// PORTS
//  clk      in   1     clock, rising edge
//  reset    in   1     asynchronous, active-high
//  ireq     in   1     fetch request; held with iaddr stable until iack
//  iaddr    in   XLEN  fetch address
//  iflush   in   1     cancel outstanding/arriving fetch (branch/jump taken)
//  iack     out  1     one-cycle fetch completion pulse
//  irdata   out  XLEN  fetched word, valid when iack=1
//  dreq     in   1     data request; held with dwe/daddr/dwdata stable until dack
//  dwe      in   1     1 = store, 0 = load
//  daddr    in   XLEN  data address (aluoutM)
//  dwdata   in   XLEN  store data (writedataM)
//  dack     out  1     one-cycle data completion pulse (loads and stores)
//  drdata   out  XLEN  load data, valid when dack=1
//  mreq     out  1     memory request, held until mack
//  mwe      out  1     memory write enable
//  maddr    out  XLEN  memory address
//  mwdata   out  XLEN  memory write data
//  mrdata   in   XLEN  memory read data, valid with mack
//  mack     in   1     memory completion; may assert in the first mreq cycle
// BEHAVIOUR
//  Reset: state=IDLE, starve_cnt=0, drop=0, all outputs 0 (mreq, mwe, maddr, mwdata, iack, dack, irdata, drdata).
//  FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D. All outputs come from registers.
//  IDLE pick (cycle T):
//    - dreq && (!ireq || iflush || starve_cnt<STARVE_MAX) -> D.
//    - else if ireq && !iflush -> I.
//    - else stay in IDLE.
//  Grant: latch the winner's addr/we/wdata. At T+1 the state is BUSY_x and mreq=1 with the latched payload.
//    - mwe=0 for any I grant.
//  BUSY_x: hold mreq and payload until mack=1.
//    - On the mack edge, capture rdata_q<=mrdata, go to RESP_x, drop mreq/mwe.
//  RESP_x: assert xack=1 for exactly one cycle; next state IDLE. No arbitration in RESP.
//    - Requester sees xack and may drop xreq at that same edge, so IDLE never re-grants a finished request.
//  Latency: req at T -> mreq at T+1 -> mack earliest T+1 -> ack at T+2. Back-to-back issue every 3 cycles minimum.
//  irdata and drdata both show rdata_q. They are meaningful only with their ack.
//    - drdata for a store is don't-care.
//  Starvation counter:
//    - On a D grant with ireq=1 and iflush=0: starve_cnt++, saturating at STARVE_MAX.
//    - On an I grant, or an arbitration with ireq=0: starve_cnt<=0.
//  Flush:
//    - iflush=1 in BUSY_I or RESP_I sets drop. The memory transaction still completes (mreq is never withdrawn).
//    - In RESP_I with drop=1, iack stays 0. drop clears on leaving RESP_I.
//    - iflush in IDLE blocks an I grant that cycle only.
//    - iflush has no effect on D transactions.
//  Simultaneous events:
//    - dreq and ireq arriving in the same IDLE cycle follow the pick rule above.
//    - A new request arriving during BUSY/RESP waits; it is never lost as long as it is held.
//  Reset mid-transaction: immediate return to IDLE with mreq=0. The in-flight transaction is abandoned; memory is reset with the system.
//  mack outside BUSY_x is ignored.
// STRUCTURE
//  Add to defines.v:
//    - CPU6_MEMARB_STATE_SIZE (3).
//    - State encodings CPU6_MEMARB_IDLE/BUSY_I/BUSY_D/RESP_I/RESP_D.
//    - Reuse CPU6_XLEN.
//  One sub-module, cpu6_memarb_prio: the pick logic plus the saturating starve_cnt register.
//  The FSM, payload latches and rdata_q stay in the top module.
// TESTING
//  1. Single load: dreq=1, dwe=0, daddr=0x100; mem mack at the first mreq cycle with 0xDEADBEEF -> mreq at T+1, dack=1 and drdata=0xDEADBEEF at T+2.
//  2. Store with 2-cycle mem wait: dwe=1, daddr=0x40, dwdata=0x12345678 -> mreq/mwe/maddr/mwdata held stable 3 cycles, single dack pulse, mwe=0 in RESP.
//  3. Contention, STARVE_MAX=4: ireq held, dreq re-raised after every dack -> exactly 4 D grants, then an I grant with iack; starve_cnt back to 0.
//  4. Flush in BUSY_I: iaddr=0x200, mem waits 3 cycles, iflush pulsed in cycle 2 -> mack consumed, iack never asserts, FSM back in IDLE, next ireq 0x300 served normally.
//  5. Same-cycle ireq+dreq with starve_cnt=0 -> D served first, I served after RESP_D; no request dropped.
//  6. Async reset asserted mid BUSY_D -> mreq, dack, iack=0 immediately; after release, IDLE, a fresh dreq completes normally.

Source files
------------

// File: rtl/cpu6_memarb_pkg.sv
// Shared types and widths for the I/D memory arbiter.
package cpu6_memarb_pkg;

  localparam int CPU6_XLEN              = 32;
  localparam int CPU6_MEMARB_STATE_SIZE = 3;

  typedef enum logic [CPU6_MEMARB_STATE_SIZE-1:0] {
    CPU6_MEMARB_IDLE   = 3'd0,
    CPU6_MEMARB_BUSY_I = 3'd1,
    CPU6_MEMARB_BUSY_D = 3'd2,
    CPU6_MEMARB_RESP_I = 3'd3,
    CPU6_MEMARB_RESP_D = 3'd4
  } memarb_state_e;

endpackage

// File: rtl/cpu6_memarb_prio.sv
// Port pick for the arbiter: D wins by default, I is forced through once
// STARVE_MAX consecutive D grants have been made while fetch was waiting.
module cpu6_memarb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic ireq_i,
  input  logic iflush_i,
  input  logic dreq_i,
  output logic grant_d_o,
  output logic grant_i_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  logic          pick_d, pick_i;

  always_comb begin
    pick_d   = dreq_i && (!ireq_i || iflush_i || (starve_q < SMAX));
    pick_i   = !pick_d && ireq_i && !iflush_i;
    starve_d = starve_q;
    if (arb_en_i) begin
      // a flushed fetch is not really waiting, so it neither counts nor clears
      if (pick_i || !ireq_i)
        starve_d = '0;
      else if (pick_d && !iflush_i && (starve_q != SMAX))
        starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign grant_d_o = arb_en_i && pick_d;
  assign grant_i_o = arb_en_i && pick_i;

endmodule

// File: rtl/cpu6_memarb.sv
// Single-ported memory shared by fetch (I) and MEM stage (D) with a locked
// grant; all outputs are registered.
module cpu6_memarb
  import cpu6_memarb_pkg::*;
#(
  parameter int XLEN       = CPU6_XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ireq,
  input  logic [XLEN-1:0] iaddr,
  input  logic            iflush,
  output logic            iack,
  output logic [XLEN-1:0] irdata,
  input  logic            dreq,
  input  logic            dwe,
  input  logic [XLEN-1:0] daddr,
  input  logic [XLEN-1:0] dwdata,
  output logic            dack,
  output logic [XLEN-1:0] drdata,
  output logic            mreq,
  output logic            mwe,
  output logic [XLEN-1:0] maddr,
  output logic [XLEN-1:0] mwdata,
  input  logic [XLEN-1:0] mrdata,
  input  logic            mack
);

  memarb_state_e   state_q, state_d;
  logic            mreq_q, mreq_d;
  logic            mwe_q, mwe_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic [XLEN-1:0] mwdata_q, mwdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            iack_q, iack_d;
  logic            dack_q, dack_d;
  logic            drop_q, drop_d;
  logic            grant_d, grant_i;

  cpu6_memarb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk       (clk),
    .reset     (reset),
    .arb_en_i  (state_q == CPU6_MEMARB_IDLE),
    .ireq_i    (ireq),
    .iflush_i  (iflush),
    .dreq_i    (dreq),
    .grant_d_o (grant_d),
    .grant_i_o (grant_i)
  );

  always_comb begin
    state_d  = state_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    drop_d   = drop_q;

    case (state_q)
      CPU6_MEMARB_IDLE: begin
        if (grant_d) begin
          state_d  = CPU6_MEMARB_BUSY_D;
          mreq_d   = 1'b1;
          mwe_d    = dwe;
          maddr_d  = daddr;
          mwdata_d = dwdata;
        end else if (grant_i) begin
          state_d  = CPU6_MEMARB_BUSY_I;
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = iaddr;
          mwdata_d = '0;
        end
      end
      CPU6_MEMARB_BUSY_I: begin
        if (iflush) drop_d = 1'b1;
        if (mack) begin
          state_d = CPU6_MEMARB_RESP_I;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          rdata_d = mrdata;
          // a flush landing on the completion edge must still suppress iack
          iack_d  = !(drop_q || iflush);
        end
      end
      CPU6_MEMARB_BUSY_D: begin
        if (mack) begin
          state_d = CPU6_MEMARB_RESP_D;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          rdata_d = mrdata;
          dack_d  = 1'b1;
        end
      end
      CPU6_MEMARB_RESP_I: begin
        state_d = CPU6_MEMARB_IDLE;
        drop_d  = 1'b0;
      end
      CPU6_MEMARB_RESP_D: state_d = CPU6_MEMARB_IDLE;
      default:            state_d = CPU6_MEMARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CPU6_MEMARB_IDLE;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
      drop_q   <= drop_d;
    end
  end

  assign mreq   = mreq_q;
  assign mwe    = mwe_q;
  assign maddr  = maddr_q;
  assign mwdata = mwdata_q;
  assign iack   = iack_q;
  assign dack   = dack_q;
  assign irdata = rdata_q;
  assign drdata = rdata_q;

endmodule
